mem_io_responder: RTL and testbench
===================================

# mem_io_responder

Memory-side responder for the LC-3 datapath's MAR/MDR bus interface. It accepts CPU read/write requests, services them from external asynchronous SRAM with a programmable number of wait states or from a memory-mapped I/O location, and returns read data on Data_to_CPU with a one-cycle Ready pulse. The block sits between the CPU datapath and the board SRAM, switches and hex displays. It is the responder end of the interface that the datapath initiates through MAR, MDR and MIO_EN.

## Interface
- WAIT_CYCLES, 2: number of SRAM access cycles per transfer; legal range 1–15.
- IO_ADDR, 16'hFFFF: address decoded as the I/O location, with switches on read and hex register on write.
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- MAR  in  16  request address from the CPU.
- MDR  in  16  write data from the CPU.
- OE  in  1  read request, level.
- WE  in  1  write request, level; wins over OE if both are high.
- Switches  in  16  raw board switches, asynchronous.
- Data_to_CPU  out  16  read data, registered and held until the next completed read.
- Ready  out  1  one-cycle completion pulse.
- HEX_data  out  16  I/O write register that drives the hex displays.
- sram_addr  out  16  registered SRAM address.
- sram_wdata  out  16  registered SRAM write data.
- sram_rdata  in  16  SRAM read data.
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes, registered.

## Operation
- Reset (asserted low) values:
  - state IDLE, Ready 0, Data_to_CPU 0, HEX_data 0.
  - sram_addr 0, sram_wdata 0, all strobes 1.
  - Switch synchronizer cleared to 0.
- The request is req = OE | WE. A write is WE=1; otherwise the request is a read.
- The FSM has four states: IDLE, ACCESS, DONE and HOLD.
- IDLE, req=1, MAR == IO_ADDR goes to DONE directly (I/O path, no SRAM strobes):
  - a write loads HEX_data <= MDR;
  - a read loads Data_to_CPU <= synchronized Switches.
- IDLE, req=1, other address goes to ACCESS:
  - latch sram_addr <= MAR and sram_wdata <= MDR;
  - latch the write flag;
  - load wait counter <= WAIT_CYCLES-1.
- ACCESS:
  - strobes: sram_ce_n=0; for a read sram_oe_n=0; for a write sram_we_n=0.
  - The counter decrements each cycle.
  - On the edge where the counter is 0, go to DONE. A read captures Data_to_CPU <= sram_rdata on that edge.
  - All strobes return to 1 on entering DONE.
- DONE: Ready=1 for exactly this cycle, then go to HOLD.
- HOLD: stay until OE=0 and WE=0, then go to IDLE. A held request never retriggers.
- Address and data are captured once, at the IDLE exit. Changes to MAR, MDR, OE or WE during ACCESS are ignored.
- A request dropped mid-ACCESS still completes: Ready pulses, then HOLD exits to IDLE on the next cycle.
- Switches pass through a two-flop synchronizer. An I/O read returns the synchronizer output at the sampling edge.
- Data_to_CPU changes only on a completed read or on reset. Writes never alter it.
- Reset asserted mid-ACCESS:
  - strobes deassert immediately (asynchronously);
  - FSM returns to IDLE;
  - no Ready pulse;
  - HEX_data cleared.

## Timing
- Edge E0 is the edge on which IDLE samples req=1.
- SRAM access:
  - strobes are active for the WAIT_CYCLES cycles following E0;
  - Ready is high in cycle WAIT_CYCLES+1 after E0;
  - read data is valid on Data_to_CPU in that same cycle.
- I/O access: Ready is high in the cycle immediately after E0.
- Minimum spacing between back-to-back requests: req must be low for at least one HOLD-sampled edge. For SRAM, the next E0 comes at least WAIT_CYCLES+3 edges after the previous E0.
- sram_addr and sram_wdata are stable from E0 until the next IDLE exit, covering the whole strobe window.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- **Reset:** hold Reset=0 with random inputs, then release.
  - Ready=0, Data_to_CPU=0, HEX_data=0, all strobes=1 throughout.
- **SRAM read, WAIT_CYCLES=2:** the SRAM model returns 16'hBEEF at address 16'h0123; OE=1, MAR=16'h0123.
  - sram_ce_n/sram_oe_n low for 2 cycles.
  - Ready high in cycle 3 after E0; Data_to_CPU=16'hBEEF.
  - Keeping OE high for 10 more cycles gives no second Ready.
- **SRAM write:** WE=1, MAR=16'h0040, MDR=16'h1234.
  - sram_we_n low for 2 cycles with addr 16'h0040 and wdata 16'h1234.
  - Ready pulse; Data_to_CPU unchanged; HEX_data unchanged.
- **I/O path:**
  - Write MAR=16'hFFFF, MDR=16'h00A5 gives HEX_data=16'h00A5 and Ready in cycle 1, with no strobe activity.
  - Switches=16'h5A5A held for 3 cycles, then read 16'hFFFF, gives Data_to_CPU=16'h5A5A.
- **Mid-access disturbance:**
  - Change MAR and drop OE during ACCESS: the original address is held, Ready still pulses once, the FSM is back in IDLE 2 cycles later.
  - OE and WE both high gives a write.
- **Reset mid-ACCESS:** assert Reset during the first ACCESS cycle.
  - Strobes are 1 in the same cycle; no Ready.
  - After release, a new read of 16'h0123 returns 16'hBEEF normally.

Source files
------------

// File: rtl/mem_io_responder.sv
// mem_io_responder
// Memory-side responder for the LC-3 MAR/MDR bus. A CPU read/write request
// is served either from external asynchronous SRAM, using a fixed number of
// strobe cycles, or from the single memory-mapped I/O location. A read of
// that location returns the synchronized switches. A write to it loads the
// hex display register. Completion is signalled by a one-cycle Ready pulse.
//
// Ports
//   Clk, Reset            clock and asynchronous active-low reset
//   MAR, MDR              request address / write data from the CPU
//   OE, WE                level read / write request (WE wins)
//   Switches              raw board switches (asynchronous)
//   Data_to_CPU           registered read data, held until the next read
//   Ready                 one-cycle completion pulse
//   HEX_data              I/O write register for the hex displays
//   sram_addr/wdata       registered SRAM address and write data
//   sram_rdata            SRAM read data
//   sram_ce_n/oe_n/we_n   registered active-low SRAM strobes
module mem_io_responder #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    input  logic        OE,
    input  logic        WE,
    input  logic [15:0] Switches,
    output logic [15:0] Data_to_CPU,
    output logic        Ready,
    output logic [15:0] HEX_data,
    output logic [15:0] sram_addr,
    output logic [15:0] sram_wdata,
    input  logic [15:0] sram_rdata,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, HOLD} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic        ready_q, ready_d;
    logic [15:0] dout_q, dout_d;
    logic [15:0] hex_q, hex_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        ce_n_q, ce_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic [15:0] sw_meta_q, sw_meta_d;
    logic [15:0] sw_sync_q, sw_sync_d;

    logic req;
    assign req = OE | WE;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        ready_d   = 1'b0;
        dout_d    = dout_q;
        hex_d     = hex_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ce_n_d    = ce_n_q;
        oe_n_d    = oe_n_q;
        we_n_d    = we_n_q;
        sw_meta_d = Switches;
        sw_sync_d = sw_meta_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (MAR == IO_ADDR) begin
                        // I/O location: no SRAM cycle, complete next cycle
                        state_d = DONE;
                        ready_d = 1'b1;
                        if (WE) hex_d  = MDR;
                        else    dout_d = sw_sync_q;
                    end else begin
                        // Address, data and direction are frozen here for
                        // the whole access; later bus changes are ignored.
                        state_d = ACCESS;
                        addr_d  = MAR;
                        wdata_d = MDR;
                        wr_d    = WE;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                        ce_n_d  = 1'b0;
                        oe_n_d  = WE;
                        we_n_d  = ~WE;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    if (!wr_q) dout_d = sram_rdata;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: state_d = HOLD;
            // Wait for the request to drop so a held level never retriggers
            HOLD: if (!req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            ready_q   <= 1'b0;
            dout_q    <= '0;
            hex_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            ready_q   <= ready_d;
            dout_q    <= dout_d;
            hex_q     <= hex_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
        end
    end

    assign Data_to_CPU = dout_q;
    assign Ready       = ready_q;
    assign HEX_data    = hex_q;
    assign sram_addr   = addr_q;
    assign sram_wdata  = wdata_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Testbench for mem_io_responder: directed requests push the expected
// Data_to_CPU / HEX_data into a scoreboard queue; a monitor pops and
// compares on every Ready pulse. Strobe windows and Ready timing are
// checked by the stimulus task against hand-computed cycle numbers.
module tb_mem_io_responder;

    localparam int W = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] MAR, MDR, Switches, sram_rdata;
    logic        OE, WE;
    logic [15:0] Data_to_CPU, HEX_data, sram_addr, sram_wdata;
    logic        Ready, sram_ce_n, sram_oe_n, sram_we_n;

    mem_io_responder #(.WAIT_CYCLES(W), .IO_ADDR(16'hFFFF)) dut (
        .Clk(Clk), .Reset(Reset), .MAR(MAR), .MDR(MDR), .OE(OE), .WE(WE),
        .Switches(Switches), .Data_to_CPU(Data_to_CPU), .Ready(Ready),
        .HEX_data(HEX_data), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n)
    );

    always #5 Clk = ~Clk;

    // Small SRAM model indexed by the low address byte
    logic [15:0] mem [0:255];
    assign sram_rdata = mem[sram_addr[7:0]];
    always @(posedge Clk)
        if (!sram_ce_n && !sram_we_n) mem[sram_addr[7:0]] <= sram_wdata;

    typedef struct {
        logic [15:0] dout;
        logic [15:0] hex;
    } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // Scoreboard monitor
    always @(negedge Clk) begin
        if (Ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ready: got Ready=1 want no pulse at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_data_to_cpu", Data_to_CPU, e.dout);
                chk("sb_hex_data", HEX_data, e.hex);
            end
        end
    end

    // One request. n = observed cycles after E0, drop_at = cycle whose
    // negedge drops the request and disturbs MAR/MDR (0 = never), gap =
    // extra idle edges after the window.
    task automatic do_req(input string name, input logic oe, input logic we,
                          input logic [15:0] addr, input logic [15:0] wdata,
                          input bit io, input int n, input int drop_at,
                          input logic [15:0] alt_addr,
                          input logic [15:0] exp_dout, input logic [15:0] exp_hex,
                          input int gap);
        exp_t e;
        int nce = 0, noe = 0, nwe = 0, nrdy = 0, rdy_at = 0, first = 0, aerr = 0;
        bit wr;
        wr = we;
        e.dout = exp_dout;
        e.hex  = exp_hex;
        exp_q.push_back(e);
        @(posedge Clk); #1;
        OE = oe; WE = we; MAR = addr; MDR = wdata;
        @(posedge Clk);  // E0
        for (int k = 1; k <= n; k++) begin
            @(negedge Clk);
            if (!sram_ce_n) begin
                nce++;
                if (first == 0) first = k;
                if (sram_addr !== addr) aerr++;
                if (wr && sram_wdata !== wdata) aerr++;
            end
            if (!sram_oe_n) noe++;
            if (!sram_we_n) nwe++;
            if (Ready) begin
                nrdy++;
                if (rdy_at == 0) rdy_at = k;
            end
            if (k == drop_at) begin
                OE = 1'b0; WE = 1'b0; MAR = alt_addr; MDR = ~wdata;
            end
        end
        OE = 1'b0; WE = 1'b0;
        repeat (gap) @(posedge Clk);
        chk({name, "_ready_count"}, nrdy, 1);
        chk({name, "_ready_cycle"}, rdy_at, io ? 1 : W + 1);
        chk({name, "_ce_cycles"}, nce, io ? 0 : W);
        chk({name, "_oe_cycles"}, noe, (io || wr) ? 0 : W);
        chk({name, "_we_cycles"}, nwe, (!io && wr) ? W : 0);
        chk({name, "_strobe_start"}, first, io ? 0 : 1);
        chk({name, "_addr_data_hold"}, aerr, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);
        mem[8'h23] = 16'hBEEF;
        Reset = 1'b0;
        OE = 1'b0; WE = 1'b0; MAR = '0; MDR = '0; Switches = '0;

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            chk("rst_ready_strobes", {Ready, sram_ce_n, sram_oe_n, sram_we_n}, 4'b0111);
            chk("rst_data_to_cpu", Data_to_CPU, 0);
            chk("rst_hex", HEX_data, 0);
            chk("rst_addr_wdata", {sram_addr, sram_wdata}, 0);
            OE = 1'($urandom); WE = 1'($urandom);
            MAR = 16'($urandom); MDR = 16'($urandom); Switches = 16'($urandom);
        end
        OE = 1'b0; WE = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        repeat (2) @(posedge Clk);

        // SRAM read, OE held 10 cycles past Ready
        do_req("sram_read", 1, 0, 16'h0123, 16'h0000, 0, W + 11, 0, 16'h0, 16'hBEEF, 16'h0000, 2);
        // SRAM write, then read it back
        do_req("sram_write", 0, 1, 16'h0040, 16'h1234, 0, 6, 0, 16'h0, 16'hBEEF, 16'h0000, 2);
        do_req("sram_readback", 1, 0, 16'h0040, 16'h0000, 0, 6, 0, 16'h0, 16'h1234, 16'h0000, 2);
        // I/O write
        do_req("io_write", 0, 1, 16'hFFFF, 16'h00A5, 1, 4, 0, 16'h0, 16'h1234, 16'h00A5, 2);
        // I/O read of switches held 3 cycles
        @(negedge Clk); Switches = 16'h5A5A;
        repeat (3) @(posedge Clk);
        do_req("io_read", 1, 0, 16'hFFFF, 16'h0000, 1, 4, 0, 16'h0, 16'h5A5A, 16'h00A5, 2);
        // MAR change and OE drop in the first ACCESS cycle; followed with no
        // gap by an I/O write that must find the FSM back in IDLE
        do_req("disturb", 1, 0, 16'h0123, 16'h0000, 0, W + 2, 1, 16'h0040, 16'hBEEF, 16'h00A5, 0);
        do_req("io_after_disturb", 0, 1, 16'hFFFF, 16'h0F0F, 1, 4, 0, 16'h0, 16'hBEEF, 16'h0F0F, 2);
        // OE and WE both high is a write
        do_req("oe_we_both", 1, 1, 16'h0040, 16'h7777, 0, 6, 0, 16'h0, 16'hBEEF, 16'h0F0F, 2);
        do_req("both_readback", 1, 0, 16'h0040, 16'h0000, 0, 6, 0, 16'h0, 16'h7777, 16'h0F0F, 2);

        // Reset in the first ACCESS cycle
        @(posedge Clk); #1;
        OE = 1'b1; MAR = 16'h0123;
        @(posedge Clk); #1;
        chk("midrst_strobes_active", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b001);
        Reset = 1'b0;
        #1;
        chk("midrst_strobes_off", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
        chk("midrst_hex_clear", HEX_data, 0);
        chk("midrst_data_clear", Data_to_CPU, 0);
        OE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk("midrst_no_ready", Ready, 0);
        end
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        do_req("read_after_rst", 1, 0, 16'h0123, 16'h0000, 0, 6, 0, 16'h0, 16'hBEEF, 16'h0000, 2);

        repeat (3) @(posedge Clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
